// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer: load/start/pause control, one decrement per tick,
// saturating penalty subtraction, sticky timeout with a one-cycle expiry pulse.
module bcd_countdown_timer #(
  parameter int                  DIGITS      = 3,
  parameter logic [4*DIGITS-1:0] INIT_BCD    = 12'h300,
  parameter logic [4*DIGITS-1:0] PENALTY_BCD = 12'h010
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  input  logic                  penalty,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  timeout,
  output logic                  expired_pulse
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic           r_running;
  logic           r_timeout;
  logic           r_expired_pulse;

  state_t         w_state_next;
  logic [W-1:0]   w_count_next;
  logic [W-1:0]   w_load_clamped;
  logic [W-1:0]   w_pen_amt;
  logic [W-1:0]   w_stage1;
  logic [W-1:0]   w_stage1_sat;
  logic [W-1:0]   w_stage2;
  logic [W-1:0]   w_run_count;
  logic [DIGITS:0] w_borrow1;
  logic [DIGITS:0] w_borrow2;

  // Stage 1 subtracts the penalty; stage 2 subtracts the tick by feeding it
  // in as the digit-0 borrow. Saturating each stage gives the same result as
  // one saturating subtraction of PENALTY_BCD + 1.
  assign w_pen_amt    = penalty ? PENALTY_BCD : '0;
  assign w_borrow1[0] = 1'b0;
  assign w_borrow2[0] = tick;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [4:0] w_diff1;
      logic [4:0] w_diff2;

      assign w_load_clamped[4*gi +: 4] =
        (load_value[4*gi +: 4] > 4'd9) ? 4'd9 : load_value[4*gi +: 4];

      assign w_diff1 = {1'b0, r_count[4*gi +: 4]} - {1'b0, w_pen_amt[4*gi +: 4]}
                     - {4'b0, w_borrow1[gi]};
      assign w_borrow1[gi+1]     = w_diff1[4];
      assign w_stage1[4*gi +: 4] = w_diff1[4] ? (w_diff1[3:0] + 4'd10) : w_diff1[3:0];

      assign w_diff2 = {1'b0, w_stage1_sat[4*gi +: 4]} - {4'b0, w_borrow2[gi]};
      assign w_borrow2[gi+1]     = w_diff2[4];
      assign w_stage2[4*gi +: 4] = w_diff2[4] ? (w_diff2[3:0] + 4'd10) : w_diff2[3:0];
    end
  endgenerate

  assign w_stage1_sat = w_borrow1[DIGITS] ? '0 : w_stage1;
  assign w_run_count  = w_borrow2[DIGITS] ? '0 : w_stage2;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_count_next = w_load_clamped;
        end else if (start) begin
          w_state_next = (r_count == '0) ? S_EXPIRED : S_RUN;
        end
      end
      S_RUN: begin
        w_count_next = w_run_count;
        if (w_run_count == '0) begin
          w_state_next = S_EXPIRED;
        end else if (pause) begin
          w_state_next = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (load) begin
          w_count_next = w_load_clamped;
          w_state_next = S_IDLE;
        end else if (start && !pause) begin
          w_state_next = S_RUN;
        end
      end
      S_EXPIRED: begin
        w_count_next = '0;
        if (load) begin
          w_count_next = w_load_clamped;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_count         <= INIT_BCD;
      r_running       <= 1'b0;
      r_timeout       <= 1'b0;
      r_expired_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_count         <= w_count_next;
      r_running       <= (w_state_next == S_RUN);
      r_timeout       <= (w_state_next == S_EXPIRED);
      r_expired_pulse <= (w_state_next == S_EXPIRED) && (r_state != S_EXPIRED);
    end
  end

  assign count         = r_count;
  assign running       = r_running;
  assign timeout       = r_timeout;
  assign expired_pulse = r_expired_pulse;

endmodule
